reg_writeback_buffer: RTL and testbench
=======================================

// Module: reg_writeback_buffer
// PURPOSE
//  Writer-side front end of the 8x8-bit register file. Accepts ALU/result writes over a valid/ready
//  handshake and queues them in a small FIFO. Drains one entry per cycle onto the register file
//  write port (rf_we/rf_waddr/rf_wdata), which commits on the following negedge.
//  Provides two bypass lookups so operand readers see pending (not yet committed) values.
// PARAMETERS
//  DATA_W  8  register data width
//  ADDR_W  3  register address width (2**ADDR_W registers)
//  DEPTH   4  FIFO entries; power of two, >=2
// PORTS
//  clk        in   1                 single clock; all state updates on posedge
//  reset_n    in   1                 synchronous, active-low reset
//  res_valid  in   1                 result write request
//  res_ready  out  1                 buffer can accept a request
//  res_addr   in   ADDR_W            destination register
//  res_data   in   DATA_W            result value
//  drain_en   in   1                 1 = register file write port available this cycle
//  rf_we      out  1                 write strobe to register file (registered)
//  rf_waddr   out  ADDR_W            write address (registered)
//  rf_wdata   out  DATA_W            write data (registered)
//  byp1_addr  in   ADDR_W            bypass lookup address, port 1
//  byp1_hit   out  1                 a pending write to byp1_addr exists
//  byp1_data  out  DATA_W            youngest pending value for byp1_addr (0 when no hit)
//  byp2_addr  in   ADDR_W            bypass lookup address, port 2
//  byp2_hit   out  1                 as byp1_hit, port 2
//  byp2_data  out  DATA_W            as byp1_data, port 2
//  count      out  $clog2(DEPTH)+1   FIFO occupancy
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge): wr_ptr=rd_ptr=0, count=0, rf_we=0, rf_waddr=0, rf_wdata=0.
//    res_ready=0 while reset_n=0; requests are ignored during reset. Reset mid-drain discards all
//    pending entries; no rf_we pulse after the reset edge.
//  - res_ready = reset_n & (count < DEPTH); combinational from count only (no same-cycle pop credit).
//  - Push: res_valid & res_ready at posedge -> {res_addr,res_data} written at wr_ptr; wr_ptr+1.
//  - Pop: at posedge, if drain_en & count>0: rf_we<=1, rf_waddr/rf_wdata<=head entry; rd_ptr+1.
//    Otherwise rf_we<=0 and rf_waddr/rf_wdata hold their previous values.
//  - Latency: request pushed at edge k into an empty FIFO -> rf_we high during cycle k+1..k+2.
//  - Push and pop in the same cycle: both occur; count unchanged; FIFO order preserved.
//  - Pointers are ADDR-of-FIFO width, wrap modulo DEPTH; count is the sole full/empty indicator.
//  - Writes to the same register are committed strictly in arrival order; none merged or dropped.
//  - Bypass (combinational): search the in-flight entry (rf_we=1) plus all valid FIFO entries;
//    youngest matching entry wins (newest FIFO entry > older FIFO entries > in-flight).
//    No match -> hit=0, data=0. An entry is visible to bypass from the cycle after its push edge
//    until the cycle in which its rf_we pulse is high (inclusive).
//  - drain_en=0 stalls draining only; pushes continue until full.
// STRUCTURE
//  - Shared package: DATA_W, ADDR_W, NUM_REGS constants; typedef wb_entry_t {addr, data}.
//  - Sub-module wb_bypass_match: age-ordered priority search over entries + in-flight slot;
//    instantiated once per bypass port.
//  - Top level holds FIFO storage, pointers, count and the registered rf_* outputs.
// TESTING
//  1. reset_n=0 two cycles with res_valid=1, res_addr=5 -> count=0, rf_we=0, res_ready=0, no push.
//  2. Push (5,12), drain_en=1 -> byp1_addr=5 hits 12 next cycle; rf_we=1 with addr 5/data 12 for
//     exactly one cycle; byp1_hit=0 after that cycle.
//  3. drain_en=0, push (0,1),(1,2),(2,3),(3,4) -> count=4, res_ready=0, 5th request held;
//     drain_en=1 -> writes 1,2,3,4 in order on consecutive cycles; res_ready=1 after first pop edge.
//  4. drain_en=0, push (3,10) then (3,20) -> byp2_addr=3 gives hit=1, data=20; drain -> rf writes
//     10 then 20 to addr 3.
//  5. count=2, drain_en=1, push (6,99) same cycle as pop -> count stays 2; 99 written after prior two.
//  6. count=3 draining, reset_n=0 one edge -> count=0, rf_we=0 next cycle, no further writes.

Source files
------------

// File: rtl/reg_writeback_buffer_pkg.sv
// Shared types and constants for the register writeback buffer.
// Entry layout is the {addr, data} pair queued toward the register file.
package reg_writeback_buffer_pkg;

  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 3;
  localparam int NUM_REGS   = 2 ** ADDR_W;
  localparam int FIFO_DEPTH = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/reg_writeback_buffer_bypass.sv
// Age-ordered bypass search over queued entries plus the in-flight write.
// Later matches override earlier ones, so the youngest match wins.
module wb_bypass_match
  import reg_writeback_buffer_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  wb_entry_t [DEPTH-1:0] entries,
  input  logic [PTR_W-1:0]      rd_ptr,
  input  logic [CNT_W-1:0]      count,
  input  logic                  fly_valid,
  input  wb_entry_t             fly,
  input  logic [ADDR_W-1:0]     addr,
  output logic                  hit,
  output logic [DATA_W-1:0]     data
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    if (fly_valid && fly.addr == addr) begin
      hit  = 1'b1;
      data = fly.data;
    end
    // walk oldest to youngest from the read pointer
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if (CNT_W'(i) < count && entries[idx].addr == addr) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/reg_writeback_buffer.sv
// Writer-side FIFO front end of the register file with two bypass ports.
// Drains one entry per cycle onto a registered write port.
module reg_writeback_buffer
  import reg_writeback_buffer_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [ADDR_W-1:0] res_addr,
  input  logic [DATA_W-1:0] res_data,
  input  logic              drain_en,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [ADDR_W-1:0] byp1_addr,
  output logic              byp1_hit,
  output logic [DATA_W-1:0] byp1_data,
  input  logic [ADDR_W-1:0] byp2_addr,
  output logic              byp2_hit,
  output logic [DATA_W-1:0] byp2_data,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t [DEPTH-1:0] mem;
  wb_entry_t             fly;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  push;
  logic                  pop;

  assign res_ready = reset_n & (count < CNT_W'(DEPTH));
  assign push      = res_valid & res_ready;
  assign pop       = drain_en & (count != '0);
  assign fly       = '{addr: rf_waddr, data: rf_wdata};

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= '{addr: res_addr, data: res_data};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rf_we    <= 1'b1;
        rf_waddr <= mem[rd_ptr].addr;
        rf_wdata <= mem[rd_ptr].data;
        rd_ptr   <= rd_ptr + 1'b1;
      end else begin
        rf_we <= 1'b0;
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  wb_bypass_match #(.DEPTH(DEPTH)) u_byp1 (
    .entries   (mem),
    .rd_ptr    (rd_ptr),
    .count     (count),
    .fly_valid (rf_we),
    .fly       (fly),
    .addr      (byp1_addr),
    .hit       (byp1_hit),
    .data      (byp1_data)
  );

  wb_bypass_match #(.DEPTH(DEPTH)) u_byp2 (
    .entries   (mem),
    .rd_ptr    (rd_ptr),
    .count     (count),
    .fly_valid (rf_we),
    .fly       (fly),
    .addr      (byp2_addr),
    .hit       (byp2_hit),
    .data      (byp2_data)
  );

endmodule

// File: tb/tb_reg_writeback_buffer.sv
// Testbench for reg_writeback_buffer: directed steps then random traffic,
// checked against a queue-based reference model.
module tb_reg_writeback_buffer;
  import reg_writeback_buffer_pkg::*;

  localparam int D = 4;

  logic              clk;
  logic              reset_n;
  logic              res_valid;
  logic              res_ready;
  logic [ADDR_W-1:0] res_addr;
  logic [DATA_W-1:0] res_data;
  logic              drain_en;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [ADDR_W-1:0] byp1_addr;
  logic              byp1_hit;
  logic [DATA_W-1:0] byp1_data;
  logic [ADDR_W-1:0] byp2_addr;
  logic              byp2_hit;
  logic [DATA_W-1:0] byp2_data;
  logic [2:0]        count;

  reg_writeback_buffer #(.DEPTH(D)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_addr  (res_addr),
    .res_data  (res_data),
    .drain_en  (drain_en),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .byp1_addr (byp1_addr),
    .byp1_hit  (byp1_hit),
    .byp1_data (byp1_data),
    .byp2_addr (byp2_addr),
    .byp2_hit  (byp2_hit),
    .byp2_data (byp2_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // reference model: pending queue plus the one in-flight write
  wb_entry_t         q[$];
  bit                m_fly;
  logic [ADDR_W-1:0] m_waddr;
  logic [DATA_W-1:0] m_wdata;
  bit                known;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic void model_byp(input logic [ADDR_W-1:0] a,
                                    output logic h,
                                    output logic [DATA_W-1:0] d);
    h = 1'b0;
    d = '0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].addr == a) begin
        h = 1'b1;
        d = q[i].data;
        return;
      end
    end
    if (m_fly && m_waddr == a) begin
      h = 1'b1;
      d = m_wdata;
    end
  endfunction

  task automatic step(input bit v, input int a, input int d,
                      input bit dr, input bit rn);
    logic              h;
    logic [DATA_W-1:0] bd;
    bit                rdy;
    bit                do_push;
    bit                do_pop;
    wb_entry_t         e;
    res_valid = v;
    res_addr  = ADDR_W'(a);
    res_data  = DATA_W'(d);
    drain_en  = dr;
    reset_n   = rn;
    #1;
    rdy = rn && (q.size() < D);
    check("res_ready", res_ready, rdy);
    if (known) begin
      model_byp(byp1_addr, h, bd);
      check("byp1_hit", byp1_hit, h);
      check("byp1_data", byp1_data, bd);
      model_byp(byp2_addr, h, bd);
      check("byp2_hit", byp2_hit, h);
      check("byp2_data", byp2_data, bd);
    end
    do_push = v && rdy;
    do_pop  = dr && (q.size() > 0);
    @(posedge clk);
    #1;
    if (!rn) begin
      q.delete();
      m_fly   = 0;
      m_waddr = '0;
      m_wdata = '0;
      known   = 1;
    end else begin
      m_fly = do_pop;
      if (do_pop) begin
        e = q.pop_front();
        m_waddr = e.addr;
        m_wdata = e.data;
      end
      if (do_push) q.push_back('{addr: ADDR_W'(a), data: DATA_W'(d)});
    end
    if (known) begin
      check("count", count, q.size());
      check("rf_we", rf_we, m_fly);
      check("rf_waddr", rf_waddr, m_waddr);
      check("rf_wdata", rf_wdata, m_wdata);
    end
    @(negedge clk);
  endtask

  initial begin
    m_fly = 0; m_waddr = '0; m_wdata = '0; known = 0;
    res_valid = 0; res_addr = '0; res_data = '0;
    drain_en = 0; reset_n = 0; byp1_addr = '0; byp2_addr = '0;
    @(negedge clk);

    // reset with a pending request
    step(1, 5, 7, 0, 0);
    step(1, 5, 7, 0, 0);
    check("t1_count", count, 0);
    check("t1_we", rf_we, 0);

    // single write and its bypass lifetime
    byp1_addr = 3'd5;
    step(1, 5, 12, 1, 1);
    step(0, 0, 0, 1, 1);
    check("t2_data", rf_wdata, 12);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);

    // fill while stalled, hold 5th, then drain in order
    byp1_addr = 3'd2;
    byp2_addr = 3'd0;
    step(1, 0, 1, 0, 1);
    step(1, 1, 2, 0, 1);
    step(1, 2, 3, 0, 1);
    step(1, 3, 4, 0, 1);
    check("t3_full", res_ready, 0);
    step(1, 4, 5, 0, 1);
    step(1, 4, 5, 1, 1);
    step(1, 4, 5, 1, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 1);

    // same register twice, youngest bypassed
    byp2_addr = 3'd3;
    step(1, 3, 10, 0, 1);
    step(1, 3, 20, 0, 1);
    step(0, 0, 0, 0, 1);
    check("t4_byp", byp2_data, 20);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1);

    // push and pop together at count=2
    byp1_addr = 3'd6;
    step(1, 1, 11, 0, 1);
    step(1, 2, 22, 0, 1);
    step(1, 6, 99, 1, 1);
    check("t5_count", count, 2);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1);

    // reset mid-drain
    step(1, 1, 31, 0, 1);
    step(1, 2, 32, 0, 1);
    step(1, 3, 33, 0, 1);
    step(0, 0, 0, 1, 0);
    check("t6_we", rf_we, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      byp1_addr = ADDR_W'($urandom_range(0, 7));
      byp2_addr = (q.size() > 0 && $urandom_range(0, 1) == 1)
                  ? q[q.size()-1].addr : ADDR_W'($urandom_range(0, 7));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7),
           $urandom_range(0, 255), $urandom_range(0, 2) != 0,
           $urandom_range(0, 60) != 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
